snn_input_loader: RTL and testbench

//  Writer/front end for the SNN core's 784x1 input-unit RAM. Takes UART RX bytes (98 = one 28x28 image,
//  LSB-first bits) and unpacks them into ram_input_unit. It then pulses start to snn_core and waits for done.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/snn_input_loader_if.sv | 32 +++
 rtl/snn_bit_unpacker.sv | 78 +++++++
 rtl/snn_input_loader.sv | 166 ++++++++++++++++
 tb/tb_snn_input_loader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared constants, loader FSM state type and the digit-to-ASCII helper
// for the SNN input front end.
package snn_pkg;

   localparam int         NUM_INPUT_BITS  = 784;
   localparam int         NUM_INPUT_BYTES = NUM_INPUT_BITS / 8;
   localparam logic [7:0] ASCII_ZERO      = 8'h30;
   localparam logic [7:0] ASCII_UNKNOWN   = 8'h3F;
   localparam int         ADDR_W          = 10;
   localparam int         BYTE_CNT_W      = 7;

   typedef enum logic [2:0] {
      LOAD,
      UNPACK,
      START,
      WAIT_CORE,
      SEND,
      TX_WAIT
   } loader_state_t;

   // Digits 0..9 map onto ofs+digit; anything larger is reported as '?'.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit,
                                                 input logic [7:0] ofs);
      return (digit <= 4'd9) ? ofs + {4'b0000, digit} : ASCII_UNKNOWN;
   endfunction

endpackage

// File: rtl/snn_input_loader_if.sv
// Signal bundle between the input loader and its surroundings: UART RX/TX
// handshakes, the snn_core start/done handshake and the input-unit RAM port.
// The loader connects through 'slave'; the environment side uses 'master'.
interface snn_input_loader_if;
   import snn_pkg::*;

   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic [ADDR_W-1:0] core_addr;
   logic              core_done;
   logic [3:0]        core_digit;
   logic              tx_done;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_d;
   logic              ram_we;
   logic              core_start;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              busy;
   logic              overrun;

   modport master (
      output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
      input  ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, busy, overrun
   );

   modport slave (
      input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
      output ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, busy, overrun
   );

endinterface

// File: rtl/snn_bit_unpacker.sv
// Serialises one received byte into single pixel bits, LSB first, and keeps
// a one-deep hold buffer so a byte arriving mid-unpack is not lost.
module snn_bit_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_i,
   input  logic       load_i,
   input  logic       buf_wr_i,
   input  logic       pop_i,
   input  logic       shift_en_i,
   input  logic       clear_i,
   output logic       bit_o,
   output logic [2:0] bit_cnt_o,
   output logic       last_bit_o,
   output logic       buf_full_o
);

   logic [7:0] shift_q, shift_d;
   logic [7:0] buf_q, buf_d;
   logic       buf_full_q, buf_full_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;

   assign bit_o      = shift_q[0];
   assign bit_cnt_o  = bit_cnt_q;
   assign last_bit_o = (bit_cnt_q == 3'd7);
   assign buf_full_o = buf_full_q;

   // Next-state for shift register, bit counter and hold buffer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      shift_d    = shift_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      bit_cnt_d  = bit_cnt_q;

      // Refill from the buffer beats a fresh RX byte, which beats shifting.
      if (pop_i) begin
         shift_d    = buf_q;
         buf_full_d = 1'b0;
      end else if (load_i) begin
         shift_d = byte_i;
      end else if (shift_en_i) begin
         shift_d = {1'b0, shift_q[7:1]};
      end

      // Bit 7 returns the counter to 0 explicitly instead of letting it overflow.
      if (shift_en_i) begin
         bit_cnt_d = last_bit_o ? 3'd0 : bit_cnt_q + 3'd1;
      end

      if (buf_wr_i) begin
         buf_d      = byte_i;
         buf_full_d = 1'b1;
      end

      if (clear_i) begin
         bit_cnt_d  = 3'd0;
         buf_full_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         shift_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         bit_cnt_q  <= '0;
      end else begin
         shift_q    <= shift_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/snn_input_loader.sv
// Front end of the SNN core: unpacks a 98-byte UART image into the 784x1
// input-unit RAM, starts the core, and returns the digit as ASCII over UART.
module snn_input_loader
   import snn_pkg::*;
#(
   parameter int         NUM_BITS  = NUM_INPUT_BITS,
   parameter int         NUM_BYTES = NUM_BITS / 8,
   parameter logic [7:0] ASCII_OFS = ASCII_ZERO
) (
   input logic               clk,
   input logic               rst_n,
   snn_input_loader_if.slave bus
);

   loader_state_t         state_q, state_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  overrun_q, overrun_d;

   logic                  up_bit, up_last, up_full;
   logic [2:0]            up_bit_cnt;
   logic                  up_load, up_buf_wr, up_pop, up_shift, up_clear;

   logic [ADDR_W-1:0]     ram_addr;
   logic                  ram_d, ram_we, core_start, tx_start;
   logic                  final_byte;

   assign final_byte = (byte_cnt_q == BYTE_CNT_W'(NUM_BYTES - 1));

   snn_bit_unpacker u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_i    (bus.rx_data),
      .load_i    (up_load),
      .buf_wr_i  (up_buf_wr),
      .pop_i     (up_pop),
      .shift_en_i(up_shift),
      .clear_i   (up_clear),
      .bit_o     (up_bit),
      .bit_cnt_o (up_bit_cnt),
      .last_bit_o(up_last),
      .buf_full_o(up_full)
   );

   // FSM next state, RAM address mux, unpacker control and sticky overrun.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      last_addr_d = last_addr_q;
      tx_data_d   = tx_data_q;
      overrun_d   = overrun_q;
      up_load     = 1'b0;
      up_buf_wr   = 1'b0;
      up_pop      = 1'b0;
      up_shift    = 1'b0;
      up_clear    = 1'b0;
      ram_addr    = last_addr_q;
      ram_d       = 1'b0;
      ram_we      = 1'b0;
      core_start  = 1'b0;
      tx_start    = 1'b0;

      unique case (state_q)
         LOAD: begin
            if (bus.rx_rdy) begin
               up_load = 1'b1;
               state_d = UNPACK;
            end
         end

         UNPACK: begin
            ram_we      = 1'b1;
            ram_addr    = {byte_cnt_q, up_bit_cnt};
            ram_d       = up_bit;
            last_addr_d = {byte_cnt_q, up_bit_cnt};
            up_shift    = 1'b1;
            if (up_last) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (final_byte) begin
                  // A byte arriving with the image already complete has nowhere to go.
                  state_d = START;
                  if (bus.rx_rdy) overrun_d = 1'b1;
               end else if (up_full) begin
                  up_pop = 1'b1;
                  if (bus.rx_rdy) overrun_d = 1'b1;
               end else if (bus.rx_rdy) begin
                  // Byte arriving as the unpack ends is taken directly, skipping LOAD.
                  up_load = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end else if (bus.rx_rdy) begin
               if (up_full) overrun_d = 1'b1;
               else         up_buf_wr = 1'b1;
            end
         end

         START: begin
            core_start = 1'b1;
            byte_cnt_d = '0;
            up_clear   = 1'b1;
            // A byte still buffered here belongs to no image and is flushed.
            if (bus.rx_rdy || up_full) overrun_d = 1'b1;
            state_d = WAIT_CORE;
         end

         WAIT_CORE: begin
            ram_addr = bus.core_addr;
            if (bus.rx_rdy) overrun_d = 1'b1;
            if (bus.core_done) begin
               tx_data_d = digit_to_ascii(bus.core_digit, ASCII_OFS);
               state_d   = SEND;
            end
         end

         SEND: begin
            tx_start = 1'b1;
            if (bus.rx_rdy) overrun_d = 1'b1;
            state_d = TX_WAIT;
         end

         TX_WAIT: begin
            if (bus.tx_done) begin
               if (bus.rx_rdy) begin
                  up_load = 1'b1;
                  state_d = UNPACK;
               end else begin
                  state_d = LOAD;
               end
            end else if (bus.rx_rdy) begin
               overrun_d = 1'b1;
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // Loader state, byte counter, last loader address, TX byte and overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         byte_cnt_q  <= '0;
         last_addr_q <= '0;
         tx_data_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         last_addr_q <= last_addr_d;
         tx_data_q   <= tx_data_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.ram_addr   = ram_addr;
   assign bus.ram_d      = ram_d;
   assign bus.ram_we     = ram_we;
   assign bus.core_start = core_start;
   assign bus.tx_start   = tx_start;
   assign bus.tx_data    = tx_data_q;
   assign bus.busy       = (state_q != LOAD);
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader: image loading into a RAM model,
// core/TX handshakes, address mux, hold buffer, overrun and reset.
module tb_snn_input_loader;
   import snn_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   snn_input_loader_if bus ();

   snn_input_loader dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [3:0] digit;
      logic [7:0] exp_tx;
      int         mode;
   } digit_vec_t;

   digit_vec_t vecs [6];

   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         cyc = 0;
   int         wr_cnt = 0;
   int         start_cnt = 0;
   int         tx_start_cnt = 0;
   int         bad_addr_cnt = 0;
   int         last_wr_cyc = 0;
   int         start_gap = 0;
   logic [9:0] last_wr_addr = '0;
   logic [9:0] start_prev_addr = '0;
   logic       ram_img [0:783];

   // RAM model and event counters, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.ram_we === 1'b1) begin
         if (bus.ram_addr > 10'd783) bad_addr_cnt = bad_addr_cnt + 1;
         else ram_img[bus.ram_addr] = bus.ram_d;
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = bus.ram_addr;
         last_wr_cyc  = cyc;
      end
      if (bus.core_start === 1'b1) begin
         start_cnt       = start_cnt + 1;
         start_gap       = cyc - last_wr_cyc;
         start_prev_addr = last_wr_addr;
      end
      if (bus.tx_start === 1'b1) tx_start_cnt = tx_start_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      if (act === exp) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input int mode, input int k);
      case (mode)
         0:       return 8'hA5;
         1:       return 8'(k * 37 + 11);
         default: return 8'(k) ^ 8'h5A;
      endcase
   endfunction

   function automatic int byte_err(input int k, input logic [7:0] b);
      int err = 0;
      for (int i = 0; i < 8; i++) if (ram_img[8 * k + i] !== b[i]) err++;
      return err;
   endfunction

   function automatic int image_err(input int mode);
      int err = 0;
      for (int k = 0; k < 98; k++) err += byte_err(k, byte_of(mode, k));
      return err;
   endfunction

   function automatic logic [31:0] out_vec();
      return 32'({bus.ram_addr, bus.ram_d, bus.ram_we, bus.core_start, bus.tx_start,
                  bus.tx_data, bus.busy, bus.overrun});
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = b;
      tick(1);
      bus.rx_rdy  = 1'b0;
      bus.rx_data = 8'h00;
   endtask

   task automatic load_bytes(input int mode, input int count, input int gap);
      for (int k = 0; k < count; k++) begin
         send_byte(byte_of(mode, k));
         tick(gap);
      end
   endtask

   task automatic do_image(input string name, input int mode, input int gap);
      int wr0;
      int st0;
      wr0 = wr_cnt;
      st0 = start_cnt;
      load_bytes(mode, 98, gap);
      tick(12);
      check({name, "_writes"}, 32'(wr_cnt - wr0), 32'd784);
      check({name, "_starts"}, 32'(start_cnt - st0), 32'd1);
      check({name, "_start_gap"}, 32'(start_gap), 32'd1);
      check({name, "_last_addr"}, 32'(start_prev_addr), 32'd783);
      check({name, "_image"}, 32'(image_err(mode)), 32'd0);
      check({name, "_bad_addr"}, 32'(bad_addr_cnt), 32'd0);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
   endtask

   task automatic finish_core(input string name, input logic [3:0] digit, input logic [7:0] exp_tx);
      int tx0;
      tx0 = tx_start_cnt;
      tick(3);
      bus.core_done  = 1'b1;
      bus.core_digit = digit;
      tick(1);
      bus.core_done  = 1'b0;
      bus.core_digit = 4'h5;
      tick(4);
      check({name, "_tx_data"}, 32'(bus.tx_data), 32'(exp_tx));
      check({name, "_tx_starts"}, 32'(tx_start_cnt - tx0), 32'd1);
      check({name, "_busy_txwait"}, 32'(bus.busy), 32'd1);
      bus.tx_done = 1'b1;
      tick(1);
      bus.tx_done = 1'b0;
      tick(1);
      check({name, "_busy_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int wr0;
      int tx0;
      int err;

      vecs[0] = '{digit: 4'd0, exp_tx: 8'h30, mode: 2};
      vecs[1] = '{digit: 4'd9, exp_tx: 8'h39, mode: 1};
      vecs[2] = '{digit: 4'hC, exp_tx: 8'h3F, mode: 2};
      vecs[3] = '{digit: 4'hA, exp_tx: 8'h3F, mode: 1};
      vecs[4] = '{digit: 4'hF, exp_tx: 8'h3F, mode: 2};
      vecs[5] = '{digit: 4'd5, exp_tx: 8'h35, mode: 1};

      bus.rx_rdy     = 1'b0;
      bus.rx_data    = 8'h00;
      bus.core_addr  = '0;
      bus.core_done  = 1'b0;
      bus.core_digit = 4'h0;
      bus.tx_done    = 1'b0;
      rst_n          = 1'b0;

      // Reset state
      tick(3);
      check("reset_outputs", out_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      check("idle_outputs", out_vec(), 32'd0);

      // Full 0xA5 image, 20 clocks between bytes
      do_image("t1_a5", 0, 18);
      check("t1_overrun", 32'(bus.overrun), 32'd0);

      // Core address pass-through during WAIT_CORE
      wr0 = wr_cnt;
      err = 0;
      for (int a = 0; a < 784; a++) begin
         bus.core_addr = 10'(a);
         @(negedge clk);
         if (bus.ram_addr !== 10'(a) || bus.ram_we !== 1'b0) err++;
         @(posedge clk);
         #1;
      end
      check("t5_addr_mux", 32'(err), 32'd0);
      check("t5_no_writes", 32'(wr_cnt - wr0), 32'd0);

      // RX dropped while the core runs
      send_byte(8'hFF);
      tick(2);
      check("t5_overrun", 32'(bus.overrun), 32'd1);
      check("t5_ram_kept", 32'(image_err(0)), 32'd0);
      check("t5_no_writes_rx", 32'(wr_cnt - wr0), 32'd0);

      // tx_done outside TX_WAIT has no effect
      tx0 = tx_start_cnt;
      bus.tx_done = 1'b1;
      tick(1);
      bus.tx_done = 1'b0;
      tick(2);
      check("stray_tx_done_busy", 32'(bus.busy), 32'd1);
      check("stray_tx_done_tx", 32'(tx_start_cnt - tx0), 32'd0);

      // Digit 7 result
      finish_core("t2_digit7", 4'd7, 8'h37);

      // Reset after 50 bytes, then a full image from address 0
      load_bytes(2, 50, 7);
      tick(2);
      rst_n = 1'b0;
      #2;
      check("t6_reset_outputs", out_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // core_done outside WAIT_CORE has no effect
      tx0 = tx_start_cnt;
      bus.core_done  = 1'b1;
      bus.core_digit = 4'd3;
      tick(1);
      bus.core_done  = 1'b0;
      tick(3);
      check("stray_core_done_busy", 32'(bus.busy), 32'd0);
      check("stray_core_done_tx", 32'(tx_start_cnt - tx0), 32'd0);
      check("stray_core_done_data", 32'(bus.tx_data), 32'd0);

      do_image("t6_full", 1, 7);
      check("t6_overrun", 32'(bus.overrun), 32'd0);
      finish_core("t6_core", 4'd1, 8'h31);

      // Digit-to-ASCII table, one image per entry
      for (int i = 0; i < 6; i++) begin
         do_image($sformatf("vec%0d", i), vecs[i].mode, 7);
         finish_core($sformatf("vec%0d", i), vecs[i].digit, vecs[i].exp_tx);
      end

      // Two bytes one clock apart: second goes through the hold buffer
      wr0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h3C;
      tick(1);
      bus.rx_data = 8'hC1;
      tick(1);
      bus.rx_rdy  = 1'b0;
      tick(20);
      check("t4_b2b_writes", 32'(wr_cnt - wr0), 32'd16);
      check("t4_b2b_byte0", 32'(byte_err(0, 8'h3C)), 32'd0);
      check("t4_b2b_byte1", 32'(byte_err(1, 8'hC1)), 32'd0);
      check("t4_b2b_overrun", 32'(bus.overrun), 32'd0);

      // Byte arriving on the last unpack cycle is accepted
      wr0 = wr_cnt;
      send_byte(8'h96);
      tick(6);
      send_byte(8'h0F);
      tick(20);
      check("t4_edge_writes", 32'(wr_cnt - wr0), 32'd16);
      check("t4_edge_byte2", 32'(byte_err(2, 8'h96)), 32'd0);
      check("t4_edge_byte3", 32'(byte_err(3, 8'h0F)), 32'd0);
      check("t4_edge_overrun", 32'(bus.overrun), 32'd0);

      // Third consecutive byte finds the buffer full and is dropped
      wr0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h81;
      tick(1);
      bus.rx_data = 8'h7E;
      tick(1);
      bus.rx_data = 8'hFF;
      tick(1);
      bus.rx_rdy  = 1'b0;
      tick(24);
      check("t4_drop_overrun", 32'(bus.overrun), 32'd1);
      check("t4_drop_writes", 32'(wr_cnt - wr0), 32'd16);
      check("t4_drop_byte4", 32'(byte_err(4, 8'h81)), 32'd0);
      check("t4_drop_byte5", 32'(byte_err(5, 8'h7E)), 32'd0);
      check("t4_drop_busy", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
